fetch_queue: RTL

- Fetch stage directly upstream of the register (R) stage.
- Drives the synchronous instruction memory (1-cycle read latency) and buffers returned instructions in a small FIFO.
- Presents one instruction per cycle in the R-stage registers (Instr_R, PC_R, Valid_R), which the hazard unit's StallIR freezes.
- Redirects from branch/jump resolution flush all wrong-path state.

---
 rtl/fetch_queue.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch stage with small return queue feeding the R stage
//
// Issues one read per cycle to a 1-cycle-latency instruction memory. Returned
// words either bypass into the R-stage registers or wait in a circular FIFO
// while the R stage is stalled. A redirect flushes R, the queue and any
// in-flight return, then restarts fetch at the target.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   ImemEn, ImemAdr     memory read issue and address (PC_F)
//   ImemRdata           word for the address issued the previous cycle
//   StallIR             hold the R-stage registers
//   Redirect, RedirectPC control-flow redirect and its target (bits [1:0] forced to 0)
//   Instr_R, PC_R, Valid_R  R-stage instruction, its PC, and valid flag
//   FetchStallCnt, RedirectCnt  performance counters
//
// Configuration: define FETCH_PERF_COUNT_EN to build the performance counters;
// without it both counter outputs are constant 0.

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module fetch_queue #(
    parameter int                    DEPTH        = 2,
    parameter logic [`WORD_SIZE-1:0] RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  ImemEn,
    output logic [`WORD_SIZE-1:0] ImemAdr,
    input  logic [31:0]           ImemRdata,
    input  logic                  StallIR,
    input  logic                  Redirect,
    input  logic [`WORD_SIZE-1:0] RedirectPC,
    output logic [31:0]           Instr_R,
    output logic [`WORD_SIZE-1:0] PC_R,
    output logic                  Valid_R,
    output logic [31:0]           FetchStallCnt,
    output logic [31:0]           RedirectCnt
);

    localparam int          W   = `WORD_SIZE;
    localparam int          CW  = $clog2(DEPTH + 1);
    localparam int          PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [W-1:0]  pc_f_q, pc_f_d;
    logic [W-1:0]  pc_prev_q, pc_prev_d;
    logic          in_flight_q, in_flight_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   instr_r_q, instr_r_d;
    logic [W-1:0]  pc_r_q, pc_r_d;
    logic          valid_r_q, valid_r_d;

    logic [31:0]   q_instr_q [DEPTH];
    logic [W-1:0]  q_pc_q [DEPTH];

    logic          push;
    logic          pop;
    logic [CW:0]   occupancy;
    logic          unused_redirect_lsbs;

    assign unused_redirect_lsbs = &{1'b0, RedirectPC[1:0]};

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Queued entries plus the in-flight word must fit in the queue, so a
    // stalled R stage can always absorb the next return without overflow.
    assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, in_flight_q};
    assign ImemEn    = !reset && !Redirect && (occupancy < (CW + 1)'(DEPTH));
    assign ImemAdr   = pc_f_q;

    assign Instr_R = instr_r_q;
    assign PC_R    = pc_r_q;
    assign Valid_R = valid_r_q;

    always_comb begin
        pc_f_d      = pc_f_q;
        pc_prev_d   = pc_prev_q;
        in_flight_d = 1'b0;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        instr_r_d   = instr_r_q;
        pc_r_d      = pc_r_q;
        valid_r_d   = valid_r_q;
        push        = 1'b0;
        pop         = 1'b0;

        if (Redirect) begin
            // Flush everything on the wrong path, including this cycle's return.
            valid_r_d = 1'b0;
            instr_r_d = NOP;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
            pc_f_d    = {RedirectPC[W-1:2], 2'b00};
        end else begin
            if (StallIR) begin
                push = in_flight_q;
            end else if (count_q != '0) begin
                pop       = 1'b1;
                push      = in_flight_q;
                instr_r_d = q_instr_q[rd_ptr_q];
                pc_r_d    = q_pc_q[rd_ptr_q];
                valid_r_d = 1'b1;
            end else if (in_flight_q) begin
                instr_r_d = ImemRdata;
                pc_r_d    = pc_prev_q;
                valid_r_d = 1'b1;
            end else begin
                instr_r_d = NOP;
                valid_r_d = 1'b0;
            end

            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (!push && pop) count_d = count_q - 1'b1;

            if (ImemEn) begin
                pc_f_d      = pc_f_q + W'(4);
                pc_prev_d   = pc_f_q;
                in_flight_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f_q      <= RESET_VECTOR;
            pc_prev_q   <= '0;
            in_flight_q <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            instr_r_q   <= NOP;
            pc_r_q      <= '0;
            valid_r_q   <= 1'b0;
        end else begin
            pc_f_q      <= pc_f_d;
            pc_prev_q   <= pc_prev_d;
            in_flight_q <= in_flight_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            instr_r_q   <= instr_r_d;
            pc_r_q      <= pc_r_d;
            valid_r_q   <= valid_r_d;
        end
    end

    // Queue storage needs no reset: entries are only read when count_q says so.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr_q[wr_ptr_q] <= ImemRdata;
            q_pc_q[wr_ptr_q]    <= pc_prev_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push && !pop) begin
            assert (count_q != CW'(DEPTH));
        end
    end

`ifdef FETCH_PERF_COUNT_EN
    logic [31:0] fetch_stall_cnt_q, fetch_stall_cnt_d;
    logic [31:0] redirect_cnt_q, redirect_cnt_d;

    always_comb begin
        fetch_stall_cnt_d = fetch_stall_cnt_q + {31'd0, !valid_r_q};
        redirect_cnt_d    = redirect_cnt_q + {31'd0, Redirect};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_stall_cnt_q <= '0;
            redirect_cnt_q    <= '0;
        end else begin
            fetch_stall_cnt_q <= fetch_stall_cnt_d;
            redirect_cnt_q    <= redirect_cnt_d;
        end
    end

    assign FetchStallCnt = fetch_stall_cnt_q;
    assign RedirectCnt   = redirect_cnt_q;
`else
    assign FetchStallCnt = '0;
    assign RedirectCnt   = '0;
`endif

endmodule
